input_route_stage: RTL and testbench

INPUT_ROUTE_STAGE -- requirements
Module: input_route_stage

---
 rtl/input_route_stage.sv | 187 ++++++++++++++++++
 tb/tb_input_route_stage.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/input_route_stage.sv
// input_route_stage
//   Link-side routing stage of a mesh router input port. Each flit arriving on
//   the link is registered toward the per-VC input buffers. The next-hop port
//   is computed by X-first dimension-ordered routing. A per-VC packet FSM
//   enforces well-formed packet framing. Flits that break framing, that target
//   a full VC buffer, or that carry an out-of-range VC id are dropped. Each
//   drop raises a one-cycle error pulse.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   data_i     : incoming flit (label, vc_id, data); head data holds x/y dest
//   valid_i    : data_i valid this cycle
//   is_full_i  : per-VC full flag from the downstream input buffers
//   data_o     : registered flit with vc_id stripped
//   write_o    : one-hot per-VC write strobe, zero when nothing is forwarded
//   out_port_o : next-hop port of the forwarded flit
//   error_o    : pulse, the flit accepted on the previous cycle was dropped

package noc_params;
  localparam int MESH_SIZE_X      = 4;
  localparam int MESH_SIZE_Y      = 4;
  localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
  localparam int VC_NUM           = 2;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE   = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  // Head flits carry x_dest in the low bits of data, y_dest just above it.
  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_novc_t;
endpackage

module input_route_stage #(
  parameter int VC_NUM    = 2,
  parameter int X_CURRENT = 0,
  parameter int Y_CURRENT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  noc_params::flit_t    data_i,
  input  logic                 valid_i,
  input  logic [VC_NUM-1:0]    is_full_i,
  output noc_params::flit_novc_t data_o,
  output logic [VC_NUM-1:0]    write_o,
  output noc_params::port_t    out_port_o,
  output logic                 error_o
);

  // state | meaning
  // IDLE  | no packet open on this VC; only HEAD or HEADTAIL accepted
  // BUSY  | packet open; BODY/TAIL accepted, routed with the stored port
  typedef enum logic {IDLE, BUSY} vc_state_t;

  localparam int DX = noc_params::DEST_ADDR_SIZE_X;
  localparam int DY = noc_params::DEST_ADDR_SIZE_Y;
  localparam logic [DX-1:0] X_C = DX'(X_CURRENT);
  localparam logic [DY-1:0] Y_C = DY'(Y_CURRENT);

  vc_state_t               r_state     [VC_NUM];
  vc_state_t               w_state_nxt [VC_NUM];
  noc_params::port_t       r_route     [VC_NUM];
  noc_params::port_t       w_route_nxt [VC_NUM];

  noc_params::flit_novc_t  r_data;
  logic [VC_NUM-1:0]       r_write;
  noc_params::port_t       r_out_port;
  logic                    r_error;

  logic [DX-1:0]           w_x_dest;
  logic [DY-1:0]           w_y_dest;
  noc_params::port_t       w_calc_port;
  noc_params::port_t       w_port;
  logic                    w_vc_ok;
  logic                    w_fwd;
  logic                    w_err;
  logic [VC_NUM-1:0]       w_write;

  // X-first dimension-ordered route from the head coordinates
  always_comb begin
    w_x_dest = data_i.data[DX-1:0];
    w_y_dest = data_i.data[DX +: DY];
    if (w_x_dest > X_C)      w_calc_port = noc_params::EAST;
    else if (w_x_dest < X_C) w_calc_port = noc_params::WEST;
    else if (w_y_dest > Y_C) w_calc_port = noc_params::SOUTH;
    else if (w_y_dest < Y_C) w_calc_port = noc_params::NORTH;
    else                     w_calc_port = noc_params::LOCAL;
  end

  always_comb begin
    w_vc_ok = (int'(data_i.vc_id) < VC_NUM);
    w_fwd   = 1'b0;
    w_err   = 1'b0;
    w_port  = r_out_port;
    for (int v = 0; v < VC_NUM; v++) begin
      w_state_nxt[v] = r_state[v];
      w_route_nxt[v] = r_route[v];
    end

    if (valid_i) begin
      if (!w_vc_ok) begin
        w_err = 1'b1;
      end else if (is_full_i[data_i.vc_id]) begin
        // full buffer overrides framing: VC state left untouched
        w_err = 1'b1;
      end else begin
        case (r_state[data_i.vc_id])
          IDLE: begin
            case (data_i.flit_label)
              noc_params::HEAD: begin
                w_fwd = 1'b1;
                w_port = w_calc_port;
                w_route_nxt[data_i.vc_id] = w_calc_port;
                w_state_nxt[data_i.vc_id] = BUSY;
              end
              noc_params::HEADTAIL: begin
                w_fwd  = 1'b1;
                w_port = w_calc_port;
              end
              default: w_err = 1'b1;
            endcase
          end
          BUSY: begin
            case (data_i.flit_label)
              noc_params::BODY: begin
                w_fwd  = 1'b1;
                w_port = r_route[data_i.vc_id];
              end
              noc_params::TAIL: begin
                w_fwd  = 1'b1;
                w_port = r_route[data_i.vc_id];
                w_state_nxt[data_i.vc_id] = IDLE;
              end
              default: w_err = 1'b1;
            endcase
          end
          default: w_err = 1'b1;
        endcase
      end
    end

    w_write = w_fwd ? (VC_NUM'(1) << data_i.vc_id) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write    <= '0;
      r_error    <= 1'b0;
      r_data     <= '0;
      r_out_port <= noc_params::LOCAL;
      for (int v = 0; v < VC_NUM; v++) begin
        r_state[v] <= IDLE;
        r_route[v] <= noc_params::LOCAL;
      end
    end else begin
      r_write    <= w_write;
      r_error    <= w_err;
      r_out_port <= w_port;
      if (w_fwd) begin
        r_data.flit_label <= data_i.flit_label;
        r_data.data       <= data_i.data;
      end
      for (int v = 0; v < VC_NUM; v++) begin
        r_state[v] <= w_state_nxt[v];
        r_route[v] <= w_route_nxt[v];
      end
    end
  end

  assign data_o     = r_data;
  assign write_o    = r_write;
  assign out_port_o = r_out_port;
  assign error_o    = r_error;

endmodule

// File: tb/tb_input_route_stage.sv
// tb_input_route_stage
//   Directed bench for input_route_stage with the router at (1,1).

module tb_input_route_stage;
  import noc_params::*;

  logic        clk = 1'b0;
  logic        rst;
  flit_t       data_i;
  logic        valid_i;
  logic [1:0]  is_full_i;
  flit_novc_t  data_o;
  logic [1:0]  write_o;
  port_t       out_port_o;
  logic        error_o;

  int errors = 0;
  int checks = 0;
  flit_novc_t exp_data;

  input_route_stage #(.VC_NUM(2), .X_CURRENT(1), .Y_CURRENT(1)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .is_full_i(is_full_i), .data_o(data_o), .write_o(write_o),
    .out_port_o(out_port_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] ew, input port_t ep,
                           input logic ee);
    chk({tag, ".write"}, 32'(write_o), 32'(ew));
    chk({tag, ".port"},  32'(out_port_o), 32'(ep));
    chk({tag, ".err"},   32'(error_o), 32'(ee));
    chk({tag, ".data"},  32'(data_o), 32'(exp_data));
  endtask

  // One flit presented for one cycle; outputs checked just after the edge.
  task automatic step(input string tag, input flit_label_t lbl, input logic vc,
                      input logic [1:0] x, input logic [1:0] y, input logic [11:0] pl,
                      input logic [1:0] full, input logic [1:0] ew, input port_t ep,
                      input logic ee);
    @(negedge clk);
    valid_i           = 1'b1;
    is_full_i         = full;
    data_i.flit_label = lbl;
    data_i.vc_id      = vc;
    data_i.data       = {pl, y, x};
    @(posedge clk);
    #1;
    if (ew != 2'b00) begin
      exp_data.flit_label = lbl;
      exp_data.data       = {pl, y, x};
    end
    check_out(tag, ew, ep, ee);
  endtask

  task automatic idle(input string tag, input port_t ep);
    @(negedge clk);
    valid_i   = 1'b0;
    is_full_i = 2'b00;
    @(posedge clk);
    #1;
    check_out(tag, 2'b00, ep, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    valid_i   = 1'b0;
    is_full_i = 2'b00;
    data_i    = '0;
    exp_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 2'b00, LOCAL, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // single packet vc0 to (3,0): EAST throughout
    step("p1_head", HEAD, 1'b0, 2'd3, 2'd0, 12'h111, 2'b00, 2'b01, EAST, 1'b0);
    step("p1_body", BODY, 1'b0, 2'd0, 2'd0, 12'h112, 2'b00, 2'b01, EAST, 1'b0);
    step("p1_tail", TAIL, 1'b0, 2'd1, 2'd2, 12'h113, 2'b00, 2'b01, EAST, 1'b0);
    idle("p1_idle", EAST);
    step("p1_orphan", BODY, 1'b0, 2'd0, 2'd0, 12'h114, 2'b00, 2'b00, EAST, 1'b1);

    // headtail vc1 to self, then orphan body
    step("ht", HEADTAIL, 1'b1, 2'd1, 2'd1, 12'h221, 2'b00, 2'b10, LOCAL, 1'b0);
    step("ht_orphan", BODY, 1'b1, 2'd3, 2'd3, 12'h222, 2'b00, 2'b00, LOCAL, 1'b1);

    // interleaved packets; body/tail coordinates deliberately misleading
    step("il_h0", HEAD, 1'b0, 2'd0, 2'd1, 12'h331, 2'b00, 2'b01, WEST,  1'b0);
    step("il_h1", HEAD, 1'b1, 2'd1, 2'd2, 12'h332, 2'b00, 2'b10, SOUTH, 1'b0);
    step("il_b0", BODY, 1'b0, 2'd3, 2'd3, 12'h333, 2'b00, 2'b01, WEST,  1'b0);
    step("il_t1", TAIL, 1'b1, 2'd3, 2'd0, 12'h334, 2'b00, 2'b10, SOUTH, 1'b0);
    step("il_t0", TAIL, 1'b0, 2'd1, 2'd1, 12'h335, 2'b00, 2'b01, WEST,  1'b0);

    // full flag on the addressed VC drops, on the other VC is ignored
    step("f_head", HEAD, 1'b0, 2'd1, 2'd0, 12'h441, 2'b00, 2'b01, NORTH, 1'b0);
    step("f_drop", BODY, 1'b0, 2'd3, 2'd3, 12'h442, 2'b01, 2'b00, NORTH, 1'b1);
    step("f_resend", BODY, 1'b0, 2'd3, 2'd3, 12'h443, 2'b00, 2'b01, NORTH, 1'b0);
    step("f_other", BODY, 1'b0, 2'd0, 2'd0, 12'h444, 2'b10, 2'b01, NORTH, 1'b0);
    step("f_tail_full", TAIL, 1'b0, 2'd0, 2'd0, 12'h445, 2'b01, 2'b00, NORTH, 1'b1);
    step("f_tail", TAIL, 1'b0, 2'd0, 2'd0, 12'h446, 2'b00, 2'b01, NORTH, 1'b0);

    // head while busy is dropped and leaves the stored route alone
    step("bh_head", HEAD, 1'b0, 2'd3, 2'd1, 12'h551, 2'b00, 2'b01, EAST, 1'b0);
    step("bh_head2", HEAD, 1'b0, 2'd0, 2'd0, 12'h552, 2'b00, 2'b00, EAST, 1'b1);
    step("bh_ht", HEADTAIL, 1'b0, 2'd1, 2'd0, 12'h553, 2'b00, 2'b00, EAST, 1'b1);
    step("bh_tail", TAIL, 1'b0, 2'd0, 2'd0, 12'h554, 2'b00, 2'b01, EAST, 1'b0);
    step("bh_after", HEADTAIL, 1'b0, 2'd1, 2'd2, 12'h555, 2'b00, 2'b01, SOUTH, 1'b0);

    // reset mid-packet, flit during reset discarded without error
    step("r_head", HEAD, 1'b0, 2'd2, 2'd2, 12'h661, 2'b00, 2'b01, EAST, 1'b0);
    @(negedge clk);
    rst               = 1'b1;
    valid_i           = 1'b1;
    data_i.flit_label = BODY;
    data_i.vc_id      = 1'b0;
    data_i.data       = 16'h6620;
    @(posedge clk);
    #1;
    exp_data = '0;
    check_out("r_during", 2'b00, LOCAL, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step("r_orphan", BODY, 1'b0, 2'd2, 2'd2, 12'h663, 2'b00, 2'b00, LOCAL, 1'b1);
    idle("r_idle", LOCAL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
